// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//
// Iterative AES round sequencer. Accepts one 128-bit block at a time, applies
// the initial AddRoundKey itself, then drives an external shared round
// datapath once per cycle for NUM_ROUNDS cycles. The round-key index for an
// external key store is generated every cycle. The finished block is held
// until the consumer takes it.
//
// Parameters
//   NUM_ROUNDS  rounds per block (10, 12 or 14)
//   CTR_W       width of the round counter and of rk_index
//
// Ports
//   clock        single clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_valid     a new block is offered
//   in_ready     block accepted this cycle (IDLE and no flush)
//   in_data      plaintext / ciphertext block
//   in_decrypt   1 = run the inverse cipher for the offered block
//   flush        synchronous abort, returns to IDLE next cycle
//   rk_index     round-key index to the key store
//   rk_data      round key for rk_index (combinational, same cycle)
//   rnd_in       state fed to the round datapath
//   rnd_key      round key fed to the round datapath
//   rnd_final    final-round variant (no (Inv)MixColumns)
//   rnd_inverse  inverse round datapath select
//   rnd_out      combinational result of the round datapath
//   out_valid    out_data holds a finished block
//   out_ready    consumer takes out_data this cycle
//   out_data     finished block
//   busy         high while a block is in ROUND or DONE
// -----------------------------------------------------------------------------
module round_sequencer #(
   parameter int NUM_ROUNDS = 10,
   parameter int CTR_W      = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   input  logic             in_decrypt,
   input  logic             flush,
   output logic [CTR_W-1:0] rk_index,
   input  logic [127:0]     rk_data,
   output logic [127:0]     rnd_in,
   output logic [127:0]     rnd_key,
   output logic             rnd_final,
   output logic             rnd_inverse,
   input  logic [127:0]     rnd_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             busy
);

   localparam logic [CTR_W-1:0] LAST = CTR_W'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      StIdle,
      StRound,
      StDone
   } state_e;

   state_e           st_q, st_d;
   logic [127:0]     blk_q, blk_d;
   logic             mode_q, mode_d;
   logic [CTR_W-1:0] r_q, r_d;
   logic             accept;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         st_q   <= StIdle;
         blk_q  <= '0;
         mode_q <= 1'b0;
         r_q    <= '0;
      end else begin
         st_q   <= st_d;
         blk_q  <= blk_d;
         mode_q <= mode_d;
         r_q    <= r_d;
      end
   end

   // -------------------------------------------------------------------------
   // Handshake and round-datapath control
   // -------------------------------------------------------------------------
   always_comb begin
      in_ready    = (st_q == StIdle) && !flush;
      accept      = in_valid && in_ready;
      rk_index    = '0;
      rnd_final   = 1'b0;
      rnd_inverse = 1'b0;
      unique case (st_q)
         // Key for the initial AddRoundKey: the inverse cipher starts from the
         // last round key, so the index follows in_decrypt before acceptance.
         StIdle: rk_index = in_decrypt ? LAST : '0;
         StRound: begin
            rk_index    = mode_q ? (LAST - r_q) : r_q;
            rnd_final   = (r_q == LAST);
            rnd_inverse = mode_q;
         end
         default: ;
      endcase
   end

   assign rnd_in    = blk_q;
   assign rnd_key   = rk_data;
   assign out_valid = (st_q == StDone);
   assign out_data  = blk_q;
   assign busy      = (st_q == StRound) || (st_q == StDone);

   // -------------------------------------------------------------------------
   // Next state
   // -------------------------------------------------------------------------
   always_comb begin
      st_d   = st_q;
      blk_d  = blk_q;
      mode_d = mode_q;
      r_d    = r_q;
      if (flush) begin
         // Abort wins over both accept and the output handshake.
         st_d = StIdle;
         r_d  = '0;
      end else begin
         unique case (st_q)
            StIdle: begin
               if (accept) begin
                  blk_d  = in_data ^ rk_data;
                  mode_d = in_decrypt;
                  r_d    = {{(CTR_W-1){1'b0}}, 1'b1};
                  st_d   = StRound;
               end
            end
            StRound: begin
               blk_d = rnd_out;
               // Counter saturates at LAST; it never wraps.
               if (r_q == LAST) begin
                  st_d = StDone;
               end else begin
                  r_d = r_q + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  st_d = StIdle;
                  r_d  = '0;
               end
            end
            default: begin
               st_d = StIdle;
               r_d  = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Invariants
   // -------------------------------------------------------------------------
   a_rounds_legal: assert property (@(posedge clock)
      (NUM_ROUNDS == 10) || (NUM_ROUNDS == 12) || (NUM_ROUNDS == 14));

   a_r_in_range: assert property (@(posedge clock) disable iff (!reset_n)
      (st_q == StRound) |-> ((r_q != '0) && (r_q <= LAST)));

   a_rk_in_range: assert property (@(posedge clock) disable iff (!reset_n)
      rk_index <= LAST);

   a_done_stable: assert property (@(posedge clock) disable iff (!reset_n)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_sequencer
//
// Two sequencers (10 and 14 rounds), each wired to a behavioural AES key
// store and round unit. Expected blocks are FIPS-197 C.1 / C.3 vectors pushed
// into per-DUT queues on accept; negedge monitors pop them on each output
// handshake and also check accept-to-valid latency.
// -----------------------------------------------------------------------------
module tb_round_sequencer;

   localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] KEY256 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         in_valid0, in_valid1;
   logic [127:0] in_data;
   logic         in_decrypt;
   logic         flush;
   logic         out_ready;

   logic         in_ready0, rnd_final0, rnd_inverse0, out_valid0, busy0;
   logic [3:0]   rk_index0;
   logic [127:0] rk_data0, rnd_in0, rnd_key0, rnd_out0, out_data0;
   logic         in_ready1, rnd_final1, rnd_inverse1, out_valid1, busy1;
   logic [3:0]   rk_index1;
   logic [127:0] rk_data1, rnd_in1, rnd_key1, rnd_out1, out_data1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [127:0] exp0_q[$];
   logic [127:0] exp1_q[$];

   always #5 clock = ~clock;

   round_sequencer #(.NUM_ROUNDS(10), .CTR_W(4)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_data(in_data), .in_decrypt(in_decrypt), .flush(flush), .rk_index(rk_index0),
      .rk_data(rk_data0), .rnd_in(rnd_in0), .rnd_key(rnd_key0), .rnd_final(rnd_final0),
      .rnd_inverse(rnd_inverse0), .rnd_out(rnd_out0), .out_valid(out_valid0),
      .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
   );

   round_sequencer #(.NUM_ROUNDS(14), .CTR_W(4)) dut14 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data), .in_decrypt(in_decrypt), .flush(flush), .rk_index(rk_index1),
      .rk_data(rk_data1), .rnd_in(rnd_in1), .rnd_key(rnd_key1), .rnd_final(rnd_final1),
      .rnd_inverse(rnd_inverse1), .rnd_out(rnd_out1), .out_valid(out_valid1),
      .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
   );

   // ---------------------------------------------------------------- AES model
   logic [7:0]   sbox [256];
   logic [7:0]   inv_sbox [256];
   logic [127:0] rk10 [11];
   logic [127:0] rk14 [15];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   task automatic init_tables();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] inv, s;
         inv = 8'h00;
         for (int j = 1; j < 256; j++) if (gm(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox[i]     = s;
         inv_sbox[s] = 8'(i);
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key, input int nk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) begin
         if (nk == 4) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else         rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic fin, input logic inv);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [7:0]   c [16];
      logic [127:0] res;
      for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
      if (!inv) begin
         for (int col = 0; col < 4; col++)
            for (int r = 0; r < 4; r++) b[r+4*col] = sbox[a[r+4*((col+r)%4)]];
         for (int col = 0; col < 4; col++) begin
            if (fin) begin
               for (int r = 0; r < 4; r++) c[r+4*col] = b[r+4*col];
            end else begin
               c[4*col]   = gm(b[4*col], 2) ^ gm(b[4*col+1], 3) ^ b[4*col+2] ^ b[4*col+3];
               c[4*col+1] = b[4*col] ^ gm(b[4*col+1], 2) ^ gm(b[4*col+2], 3) ^ b[4*col+3];
               c[4*col+2] = b[4*col] ^ b[4*col+1] ^ gm(b[4*col+2], 2) ^ gm(b[4*col+3], 3);
               c[4*col+3] = gm(b[4*col], 3) ^ b[4*col+1] ^ b[4*col+2] ^ gm(b[4*col+3], 2);
            end
         end
         for (int i = 0; i < 16; i++) res[127-8*i -: 8] = c[i] ^ k[127-8*i -: 8];
      end else begin
         for (int col = 0; col < 4; col++)
            for (int r = 0; r < 4; r++) b[r+4*((col+r)%4)] = inv_sbox[a[r+4*col]];
         for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
         for (int col = 0; col < 4; col++) begin
            if (fin) begin
               for (int r = 0; r < 4; r++) c[r+4*col] = b[r+4*col];
            end else begin
               c[4*col]   = gm(b[4*col], 14) ^ gm(b[4*col+1], 11) ^ gm(b[4*col+2], 13)
                            ^ gm(b[4*col+3], 9);
               c[4*col+1] = gm(b[4*col], 9) ^ gm(b[4*col+1], 14) ^ gm(b[4*col+2], 11)
                            ^ gm(b[4*col+3], 13);
               c[4*col+2] = gm(b[4*col], 13) ^ gm(b[4*col+1], 9) ^ gm(b[4*col+2], 14)
                            ^ gm(b[4*col+3], 11);
               c[4*col+3] = gm(b[4*col], 11) ^ gm(b[4*col+1], 13) ^ gm(b[4*col+2], 9)
                            ^ gm(b[4*col+3], 14);
            end
         end
         for (int i = 0; i < 16; i++) res[127-8*i -: 8] = c[i];
      end
      return res;
   endfunction

   always_comb rk_data0 = (rk_index0 <= 4'd10) ? rk10[rk_index0] : '0;
   always_comb rk_data1 = (rk_index1 <= 4'd14) ? rk14[rk_index1] : '0;
   always_comb rnd_out0 = aes_round(rnd_in0, rnd_key0, rnd_final0, rnd_inverse0);
   always_comb rnd_out1 = aes_round(rnd_in1, rnd_key1, rnd_final1, rnd_inverse1);

   // ---------------------------------------------------------------- checking
   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event with no matching expectation (t=%0t)", name, $time);
   endtask

   int   samp0 = 0, samp1 = 0;
   int   acc0_q[$];
   int   acc1_q[$];
   logic ov0_prev = 1'b0, ov1_prev = 1'b0;

   always @(negedge clock) begin
      samp0++;
      if (reset_n) begin
         if (in_valid0 && in_ready0) acc0_q.push_back(samp0);
         if (out_valid0 && !ov0_prev) begin
            if (acc0_q.size() == 0) flag("out_valid0_spurious");
            else check("latency0", 128'(samp0 - acc0_q.pop_front()), 11);
         end
         if (out_valid0 && out_ready && !flush) begin
            if (exp0_q.size() == 0) flag("out_data0_unexpected");
            else check("out_data0", out_data0, exp0_q.pop_front());
         end
         if (flush) acc0_q.delete();
         check("rk_index0_range", rk_index0 <= 4'd10, 1);
         if (!busy0) check("rnd_ctl0_idle", {rnd_final0, rnd_inverse0}, 0);
      end else begin
         acc0_q.delete();
      end
      ov0_prev = reset_n && out_valid0;
   end

   always @(negedge clock) begin
      samp1++;
      if (reset_n) begin
         if (in_valid1 && in_ready1) acc1_q.push_back(samp1);
         if (out_valid1 && !ov1_prev) begin
            if (acc1_q.size() == 0) flag("out_valid1_spurious");
            else check("latency1", 128'(samp1 - acc1_q.pop_front()), 15);
         end
         if (out_valid1 && out_ready && !flush) begin
            if (exp1_q.size() == 0) flag("out_data1_unexpected");
            else check("out_data1", out_data1, exp1_q.pop_front());
         end
         if (flush) acc1_q.delete();
      end else begin
         acc1_q.delete();
      end
      ov1_prev = reset_n && out_valid1;
   end

   // ---------------------------------------------------------------- stimulus
   task automatic send(input int which, input logic [127:0] data, input logic dec,
                       input logic [127:0] exp);
      bit done;
      done = 1'b0;
      @(posedge clock);
      #1;
      in_data    = data;
      in_decrypt = dec;
      if (which == 0) in_valid0 = 1'b1;
      else            in_valid1 = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clock);
         if (which == 0 && in_ready0) begin
            done = 1'b1;
            check("rk_index0_idle", rk_index0, dec ? 10 : 0);
         end else if (which == 1 && in_ready1) begin
            done = 1'b1;
            check("rk_index1_idle", rk_index1, dec ? 14 : 0);
         end
      end
      check("send_accepted", done, 1);
      @(posedge clock);
      #1;
      in_valid0  = 1'b0;
      in_valid1  = 1'b0;
      in_decrypt = 1'b0;
      if (done) begin
         if (which == 0) exp0_q.push_back(exp);
         else            exp1_q.push_back(exp);
      end
   endtask

   task automatic drain(input int which);
      int t;
      t = 0;
      while (((which == 0) ? exp0_q.size() : exp1_q.size()) != 0 && t < 200) begin
         @(negedge clock);
         t++;
      end
      check("drain", (which == 0) ? exp0_q.size() : exp1_q.size(), 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      in_valid0  = 1'b0;
      in_valid1  = 1'b0;
      in_data    = '0;
      in_decrypt = 1'b0;
      flush      = 1'b0;
      out_ready  = 1'b1;
      init_tables();
      expand({KEY128, 128'h0}, 4);
      expand(KEY256, 8);

      // Reset values
      repeat (2) @(negedge clock);
      check("rst_out_valid", out_valid0, 0);
      check("rst_busy", busy0, 0);
      check("rst_state", rnd_in0, 0);
      check("rst_ctl", {rnd_final0, rnd_inverse0}, 0);
      check("rst_rk_index", rk_index0, 0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      check("in_ready_after_reset", in_ready0, 1);

      // FIPS-197 C.1 encrypt
      send(0, PT, 1'b0, CT128);
      drain(0);

      // C.1 decrypt, key index walks 10 (IDLE) then 9..0
      send(0, CT128, 1'b1, PT);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         check("dec_rk_index", rk_index0, 10 - k);
         check("dec_rnd_inverse", rnd_inverse0, 1);
         check("dec_rnd_final", rnd_final0, (k == 10));
      end
      drain(0);

      // Back-pressure: DONE held with a second block already offered
      out_ready = 1'b0;
      send(0, PT, 1'b0, CT128);
      fork
         send(0, CT128, 1'b1, PT);
         begin
            int t;
            t = 0;
            while (!out_valid0 && t < 50) begin
               @(negedge clock);
               t++;
            end
            for (int i = 0; i < 5; i++) begin
               if (i > 0) @(negedge clock);
               check("bp_out_valid", out_valid0, 1);
               check("bp_out_data", out_data0, CT128);
               check("bp_in_ready", in_ready0, 0);
            end
            @(posedge clock);
            #1 out_ready = 1'b1;
            @(negedge clock);
            check("bp_handshake_in_ready", in_ready0, 0);
            @(negedge clock);
            check("bp_after_busy", busy0, 0);
            check("bp_after_in_ready", in_ready0, 1);
         end
      join
      drain(0);

      // Flush beats accept in IDLE
      @(posedge clock);
      #1;
      flush     = 1'b1;
      in_valid0 = 1'b1;
      in_data   = PT;
      @(negedge clock);
      check("flush_idle_in_ready", in_ready0, 0);
      @(posedge clock);
      #1;
      flush     = 1'b0;
      in_valid0 = 1'b0;
      @(negedge clock);
      check("flush_idle_busy", busy0, 0);

      // Flush at round 4
      send(0, PT, 1'b0, CT128);
      repeat (3) @(posedge clock);
      #1 flush = 1'b1;
      @(negedge clock);
      check("flush_round4_rk", rk_index0, 4);
      @(posedge clock);
      #1 flush = 1'b0;
      void'(exp0_q.pop_back());
      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         check("flush_no_out_valid", out_valid0, 0);
      end
      check("flush_busy", busy0, 0);
      send(0, PT, 1'b0, CT128);
      drain(0);

      // Asynchronous reset at round 7
      send(0, PT, 1'b0, CT128);
      repeat (6) @(posedge clock);
      #3 check("rst7_rk", rk_index0, 7);
      reset_n = 1'b0;
      #1;
      check("rst7_busy", busy0, 0);
      check("rst7_out_valid", out_valid0, 0);
      check("rst7_state", rnd_in0, 0);
      check("rst7_ctl", {rnd_final0, rnd_inverse0}, 0);
      check("rst7_rk_index", rk_index0, 0);
      void'(exp0_q.pop_back());
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      check("rst7_in_ready", in_ready0, 1);
      repeat (12) @(negedge clock);
      check("rst7_no_out_valid", out_valid0, 0);
      send(0, PT, 1'b0, CT128);
      drain(0);

      // FIPS-197 C.3 (AES-256) on the 14-round instance
      send(1, PT, 1'b0, CT256);
      drain(1);
      send(1, CT256, 1'b1, PT);
      drain(1);

      repeat (2) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
